// File: rtl/axis_spi_arbiter_pkg.sv
// Shared types and reset constants for the AXI-Stream SPI arbiter.
package axis_spi_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CFG, XFER, DRAIN} state_e;

  localparam int DIV_RST  = 2;
  localparam int WAIT_RST = 1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request after the last winner, wrapping around.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] last,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    int k;
    k   = 0;
    vld = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (en && !vld && req[k]) begin
        vld = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/axis_spi_arbiter.sv
// Packet-granular round-robin sharing of one axis_spi_master; grant is held
// until the master returns the RX beat carrying tlast.
module axis_spi_arbiter
  import axis_spi_arbiter_pkg::*;
#(
  parameter int REQ_NUM       = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 32,
  parameter int WAIT_WIDTH    = 32,
  parameter int SLAVE_NUM     = 1,
  parameter int ADDR_WIDTH    = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
  parameter int GNT_WIDTH     = $clog2(REQ_NUM)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]      req_tdata_i,
  input  logic [REQ_NUM-1:0]                 req_tvalid_i,
  input  logic [REQ_NUM-1:0]                 req_tlast_i,
  output logic [REQ_NUM-1:0]                 req_tready_o,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [REQ_NUM-1:0]                 req_cpol_i,
  input  logic [REQ_NUM-1:0]                 req_cpha_i,
  input  logic [REQ_NUM*DIVIDER_WIDTH-1:0]   req_div_i,
  input  logic [REQ_NUM*WAIT_WIDTH-1:0]      req_wait_i,
  output logic [DATA_WIDTH-1:0]              rsp_tdata_o,
  output logic [REQ_NUM-1:0]                 rsp_tvalid_o,
  output logic                               rsp_tlast_o,
  input  logic [REQ_NUM-1:0]                 rsp_tready_i,
  output logic [DATA_WIDTH-1:0]              spi_tdata_o,
  output logic                               spi_tvalid_o,
  output logic                               spi_tlast_o,
  input  logic                               spi_tready_i,
  input  logic [DATA_WIDTH-1:0]              spi_rx_tdata_i,
  input  logic                               spi_rx_tvalid_i,
  input  logic                               spi_rx_tlast_i,
  output logic                               spi_rx_tready_o,
  output logic [ADDR_WIDTH-1:0]              spi_addr_o,
  output logic                               spi_cpol_o,
  output logic                               spi_cpha_o,
  output logic [DIVIDER_WIDTH-1:0]           spi_div_o,
  output logic [WAIT_WIDTH-1:0]              spi_wait_o,
  output logic [GNT_WIDTH-1:0]               gnt_o,
  output logic                               busy_o
);
  state_e               state;
  logic [GNT_WIDTH-1:0] last_q;
  logic                 arb_vld;
  logic [GNT_WIDTH-1:0] arb_idx;
  logic                 rx_act, tx_last_hs, rx_last_hs;

  rr_arbiter #(.N(REQ_NUM), .IDX_W(GNT_WIDTH)) u_rr (
    .req  (req_tvalid_i),
    .en   (state == IDLE),
    .last (last_q),
    .vld  (arb_vld),
    .idx  (arb_idx)
  );

  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic                     sel_cpol, sel_cpha;
  logic [DIVIDER_WIDTH-1:0] sel_div;
  logic [WAIT_WIDTH-1:0]    sel_wait;
  logic [DATA_WIDTH-1:0]    g_tdata;
  logic                     g_tvalid, g_tlast, g_rsp_tready;

  // sel_* follow the arbitration winner, g_* follow the held grant
  always_comb begin
    sel_addr = '0; sel_cpol = 1'b0; sel_cpha = 1'b0; sel_div = '0; sel_wait = '0;
    g_tdata = '0; g_tvalid = 1'b0; g_tlast = 1'b0; g_rsp_tready = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (arb_idx == GNT_WIDTH'(k)) begin
        sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cpol = req_cpol_i[k];
        sel_cpha = req_cpha_i[k];
        sel_div  = req_div_i[k*DIVIDER_WIDTH +: DIVIDER_WIDTH];
        sel_wait = req_wait_i[k*WAIT_WIDTH +: WAIT_WIDTH];
      end
      if (gnt_o == GNT_WIDTH'(k)) begin
        g_tdata      = req_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        g_tvalid     = req_tvalid_i[k];
        g_tlast      = req_tlast_i[k];
        g_rsp_tready = rsp_tready_i[k];
      end
    end
  end

  assign rx_act      = (state == XFER) || (state == DRAIN);
  assign busy_o      = (state != IDLE);
  assign spi_tdata_o = g_tdata;
  assign spi_tlast_o = g_tlast;
  assign rsp_tdata_o = spi_rx_tdata_i;
  assign rsp_tlast_o = spi_rx_tlast_i;

  always_comb begin
    spi_tvalid_o = (state == XFER) && g_tvalid;
    req_tready_o = '0;
    rsp_tvalid_o = '0;
    if (state == XFER) req_tready_o[gnt_o] = spi_tready_i;
    if (rx_act) begin
      rsp_tvalid_o[gnt_o] = spi_rx_tvalid_i;
      spi_rx_tready_o     = g_rsp_tready;
    end else begin
      // stray RX beats are dropped when idle; held low while in reset
      spi_rx_tready_o = !rst_i;
    end
  end

  assign tx_last_hs = spi_tvalid_o && spi_tready_i && spi_tlast_o;
  assign rx_last_hs = rx_act && spi_rx_tvalid_i && spi_rx_tready_o && spi_rx_tlast_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt_o      <= '0;
      last_q     <= GNT_WIDTH'(REQ_NUM - 1);
      spi_addr_o <= '0;
      spi_cpol_o <= 1'b0;
      spi_cpha_o <= 1'b0;
      spi_div_o  <= DIVIDER_WIDTH'(DIV_RST);
      spi_wait_o <= WAIT_WIDTH'(WAIT_RST);
    end else begin
      case (state)
        IDLE: if (arb_vld) begin
          gnt_o      <= arb_idx;
          spi_addr_o <= sel_addr;
          spi_cpol_o <= sel_cpol;
          spi_cpha_o <= sel_cpha;
          spi_div_o  <= sel_div;
          spi_wait_o <= sel_wait;
          state      <= CFG;
        end
        CFG:  state <= XFER;
        XFER: if (tx_last_hs) begin
          if (rx_last_hs) begin
            state  <= IDLE;
            last_q <= gnt_o;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: if (rx_last_hs) begin
          state  <= IDLE;
          last_q <= gnt_o;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_spi_arbiter.sv
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_axis_spi_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_tdata;
  logic [1:0]  req_tvalid, req_tlast, req_tready;
  logic [1:0]  req_addr, req_cpol, req_cpha;
  logic [63:0] req_div, req_wt;
  logic [7:0]  rsp_tdata;
  logic [1:0]  rsp_tvalid, rsp_tready;
  logic        rsp_tlast;
  logic [7:0]  spi_tdata, spi_rx_tdata;
  logic        spi_tvalid, spi_tlast, spi_tready;
  logic        spi_rx_tvalid, spi_rx_tlast, spi_rx_tready;
  logic        spi_addr, spi_cpol, spi_cpha, gnt, busy;
  logic [31:0] spi_div, spi_wt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_spi_arbiter #(.REQ_NUM(2), .DATA_WIDTH(8), .DIVIDER_WIDTH(32),
                     .WAIT_WIDTH(32), .SLAVE_NUM(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_tdata_i(req_tdata), .req_tvalid_i(req_tvalid), .req_tlast_i(req_tlast),
    .req_tready_o(req_tready), .req_addr_i(req_addr), .req_cpol_i(req_cpol),
    .req_cpha_i(req_cpha), .req_div_i(req_div), .req_wait_i(req_wt),
    .rsp_tdata_o(rsp_tdata), .rsp_tvalid_o(rsp_tvalid), .rsp_tlast_o(rsp_tlast),
    .rsp_tready_i(rsp_tready),
    .spi_tdata_o(spi_tdata), .spi_tvalid_o(spi_tvalid), .spi_tlast_o(spi_tlast),
    .spi_tready_i(spi_tready),
    .spi_rx_tdata_i(spi_rx_tdata), .spi_rx_tvalid_i(spi_rx_tvalid),
    .spi_rx_tlast_i(spi_rx_tlast), .spi_rx_tready_o(spi_rx_tready),
    .spi_addr_o(spi_addr), .spi_cpol_o(spi_cpol), .spi_cpha_o(spi_cpha),
    .spi_div_o(spi_div), .spi_wait_o(spi_wt), .gnt_o(gnt), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic g, input logic [31:0] ediv, input logic eaddr, input bit fast);
    logic [1:0] oh;
    oh = g ? 2'b10 : 2'b01;
    tick;
    `CHK("pkt_cfg_busy", busy, 1'b1);
    `CHK("pkt_cfg_gnt", gnt, g);
    `CHK("pkt_cfg_div", spi_div, ediv);
    `CHK("pkt_cfg_addr", spi_addr, eaddr);
    `CHK("pkt_cfg_tvalid", spi_tvalid, 1'b0);
    tick;
    req_tdata = {8'h1A, 8'h0A}; req_tlast = 2'b00;
    #1;
    `CHK("pkt_b0_tvalid", spi_tvalid, 1'b1);
    `CHK("pkt_b0_tdata", spi_tdata, g ? 8'h1A : 8'h0A);
    `CHK("pkt_b0_tready", req_tready, oh);
    `CHK("pkt_b0_tlast", spi_tlast, 1'b0);
    tick;
    req_tdata = {8'h1B, 8'h0B}; req_tlast = 2'b11;
    spi_rx_tvalid = fast; spi_rx_tlast = 1'b1; spi_rx_tdata = 8'hE0;
    #1;
    `CHK("pkt_b1_tdata", spi_tdata, g ? 8'h1B : 8'h0B);
    `CHK("pkt_b1_tlast", spi_tlast, 1'b1);
    `CHK("pkt_b1_rvalid", rsp_tvalid, fast ? oh : 2'b00);
    tick;
    req_tlast = 2'b00; spi_rx_tvalid = 1'b0;
    if (!fast) begin
      #1;
      `CHK("pkt_drain_busy", busy, 1'b1);
      `CHK("pkt_drain_tvalid", spi_tvalid, 1'b0);
      `CHK("pkt_drain_gnt", gnt, g);
      spi_rx_tvalid = 1'b1;
      #1;
      `CHK("pkt_drain_rvalid", rsp_tvalid, oh);
      `CHK("pkt_drain_rready", spi_rx_tready, 1'b1);
      tick;
      spi_rx_tvalid = 1'b0;
    end
    #1;
    `CHK("pkt_end_busy", busy, 1'b0);
    `CHK("pkt_end_tready", req_tready, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    req_tdata = '0; req_tvalid = '0; req_tlast = '0;
    req_addr = 2'b10; req_cpol = '0; req_cpha = '0;
    req_div = {32'd8, 32'd4}; req_wt = {32'd9, 32'd5};
    rsp_tready = 2'b11; spi_tready = 1'b1;
    spi_rx_tdata = '0; spi_rx_tvalid = 1'b0; spi_rx_tlast = 1'b0;
    tick; tick;
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_gnt", gnt, 1'b0);
    `CHK("rst_tready", req_tready, 2'b00);
    `CHK("rst_rvalid", rsp_tvalid, 2'b00);
    `CHK("rst_tvalid", spi_tvalid, 1'b0);
    `CHK("rst_rready", spi_rx_tready, 1'b0);
    `CHK("rst_cpol", spi_cpol, 1'b0);
    `CHK("rst_cpha", spi_cpha, 1'b0);
    `CHK("rst_addr", spi_addr, 1'b0);
    `CHK("rst_div", spi_div, 32'd2);
    `CHK("rst_wait", spi_wt, 32'd1);
    rst = 1'b0;
    tick;

    spi_rx_tvalid = 1'b1; spi_rx_tdata = 8'h77;
    #1;
    `CHK("stray_rready", spi_rx_tready, 1'b1);
    `CHK("stray_rvalid", rsp_tvalid, 2'b00);
    tick;
    spi_rx_tvalid = 1'b0;
    `CHK("stray_busy", busy, 1'b0);

    req_cpol = 2'b01; req_cpha = 2'b01;
    req_tvalid = 2'b01; req_tdata = {8'h00, 8'hA5}; req_tlast = 2'b00;
    #1;
    `CHK("idle_tready", req_tready, 2'b00);
    `CHK("idle_tvalid", spi_tvalid, 1'b0);
    tick;
    `CHK("cfg_busy", busy, 1'b1);
    `CHK("cfg_gnt", gnt, 1'b0);
    `CHK("cfg_cpol", spi_cpol, 1'b1);
    `CHK("cfg_cpha", spi_cpha, 1'b1);
    `CHK("cfg_div", spi_div, 32'd4);
    `CHK("cfg_wait", spi_wt, 32'd5);
    `CHK("cfg_tvalid", spi_tvalid, 1'b0);
    tick;
    `CHK("x0_tvalid", spi_tvalid, 1'b1);
    `CHK("x0_tdata", spi_tdata, 8'hA5);
    `CHK("x0_tready", req_tready, 2'b01);
    req_cpol = 2'b00;
    tick;
    req_tdata = {8'h00, 8'h3C}; req_tlast = 2'b01;
    spi_rx_tvalid = 1'b1; spi_rx_tdata = 8'h11; spi_rx_tlast = 1'b0;
    #1;
    `CHK("x1_tdata", spi_tdata, 8'h3C);
    `CHK("x1_tlast", spi_tlast, 1'b1);
    `CHK("x1_cpol_held", spi_cpol, 1'b1);
    `CHK("x1_rvalid", rsp_tvalid, 2'b01);
    `CHK("x1_rdata", rsp_tdata, 8'h11);
    `CHK("x1_rready", spi_rx_tready, 1'b1);
    tick;
    req_tlast = 2'b00; req_tdata = {8'h00, 8'h99};
    spi_rx_tdata = 8'h22; spi_rx_tlast = 1'b1;
    #1;
    `CHK("dr_busy", busy, 1'b1);
    `CHK("dr_tvalid", spi_tvalid, 1'b0);
    `CHK("dr_tready", req_tready, 2'b00);
    `CHK("dr_rvalid", rsp_tvalid, 2'b01);
    `CHK("dr_rlast", rsp_tlast, 1'b1);
    `CHK("dr_rdata", rsp_tdata, 8'h22);
    `CHK("dr_cpol", spi_cpol, 1'b1);
    `CHK("dr_div", spi_div, 32'd4);
    req_tvalid = 2'b00;
    tick;
    spi_rx_tvalid = 1'b0; spi_rx_tlast = 1'b0;
    #1;
    `CHK("single_done", busy, 1'b0);

    rst = 1'b1;
    tick;
    rst = 1'b0; req_cpol = '0; req_cpha = '0; req_tvalid = 2'b11;
    pkt(1'b0, 32'd4, 1'b0, 1'b0);
    pkt(1'b1, 32'd8, 1'b1, 1'b1);
    pkt(1'b0, 32'd4, 1'b0, 1'b1);
    pkt(1'b1, 32'd8, 1'b1, 1'b0);

    tick;
    `CHK("bp_cfg_gnt", gnt, 1'b0);
    tick;
    req_tdata = {8'h1B, 8'h0B}; req_tlast = 2'b11;
    #1;
    `CHK("bp_tlast", spi_tlast, 1'b1);
    tick;
    req_tlast = 2'b00; rsp_tready = 2'b00;
    spi_rx_tvalid = 1'b1; spi_rx_tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      `CHK("bp_busy", busy, 1'b1);
      `CHK("bp_rready", spi_rx_tready, 1'b0);
      `CHK("bp_gnt", gnt, 1'b0);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $error("FAIL bp_loop_busy: observed %0b", busy);
      end
      n_vec++;
      if (spi_rx_tready !== 1'b0) begin
        n_err++;
        $error("FAIL bp_loop_rready: observed %0b", spi_rx_tready);
      end
      n_vec++;
      if (gnt !== 1'b0) begin
        n_err++;
        $error("FAIL bp_loop_gnt: observed %0b", gnt);
      end
      tick;
    end
    rsp_tready = 2'b11;
    #1;
    `CHK("bp_release_rready", spi_rx_tready, 1'b1);
    `CHK("bp_release_rvalid", rsp_tvalid, 2'b01);
    tick;
    spi_rx_tvalid = 1'b0; spi_rx_tlast = 1'b0;
    #1;
    `CHK("bp_idle", busy, 1'b0);
    tick;
    `CHK("bp_next_gnt", gnt, 1'b1);

    tick;
    req_tdata = {8'h1A, 8'h0A};
    #1;
    `CHK("mr_tready", req_tready, 2'b10);
    tick;
    rst = 1'b1;
    tick;
    spi_rx_tvalid = 1'b1;
    #1;
    `CHK("mr_busy", busy, 1'b0);
    `CHK("mr_gnt", gnt, 1'b0);
    `CHK("mr_tready", req_tready, 2'b00);
    `CHK("mr_tvalid", spi_tvalid, 1'b0);
    `CHK("mr_rready", spi_rx_tready, 1'b0);
    `CHK("mr_rvalid", rsp_tvalid, 2'b00);
    rst = 1'b0; spi_rx_tvalid = 1'b0;
    tick;
    `CHK("mr_regrant_gnt", gnt, 1'b0);
    `CHK("mr_regrant_busy", busy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/axis_spi_arbiter.md
Name: axis_spi_arbiter

Overview:
- Shares one axis_spi_master between REQ_NUM requesters.
- Arbitration is round-robin on packet boundaries: a packet is the TX beats up to and including tlast.
- Holds the grant until the SPI master returns the RX beat carrying tlast, so each packet's chip-select frame, wait time and responses belong to one requester.
- Registers the granted requester's SPI configuration (slave address, CPOL/CPHA, divider, wait time) and drives it to the master for the whole packet.

Parameters:
- REQ_NUM, 2, number of requesters (≥2).
- DATA_WIDTH, 8, SPI word width.
- DIVIDER_WIDTH, 32, clock divider width.
- WAIT_WIDTH, 32, inter-packet wait width.
- SLAVE_NUM, 1, SPI slaves on the bus.
- ADDR_WIDTH, $clog2(SLAVE_NUM) (1 if SLAVE_NUM==1), slave address width.
- GNT_WIDTH, $clog2(REQ_NUM), grant index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_tdata_i  in  REQ_NUM*DATA_WIDTH  requester TX data, requester k at slice k.
- req_tvalid_i  in  REQ_NUM  requester TX valid.
- req_tlast_i  in  REQ_NUM  requester TX last (ends packet).
- req_tready_o  out  REQ_NUM  requester TX ready.
- req_addr_i  in  REQ_NUM*ADDR_WIDTH  per-requester slave address.
- req_cpol_i  in  REQ_NUM  per-requester CPOL.
- req_cpha_i  in  REQ_NUM  per-requester CPHA.
- req_div_i  in  REQ_NUM*DIVIDER_WIDTH  per-requester clock divider.
- req_wait_i  in  REQ_NUM*WAIT_WIDTH  per-requester wait time.
- rsp_tdata_o  out  DATA_WIDTH  RX data, broadcast to all requesters.
- rsp_tvalid_o  out  REQ_NUM  RX valid, granted requester only.
- rsp_tlast_o  out  1  RX last.
- rsp_tready_i  in  REQ_NUM  requester RX ready.
- spi_tdata_o / spi_tvalid_o / spi_tlast_o  out  DATA_WIDTH/1/1  to master s_axis.
- spi_tready_i  in  1  from master s_axis.
- spi_rx_tdata_i / spi_rx_tvalid_i / spi_rx_tlast_i  in  DATA_WIDTH/1/1  from master m_axis.
- spi_rx_tready_o  out  1  to master m_axis.
- spi_addr_o / spi_cpol_o / spi_cpha_o / spi_div_o / spi_wait_o  out  ADDR/1/1/DIVIDER/WAIT  registered config to master.
- gnt_o  out  GNT_WIDTH  current grant index.
- busy_o  out  1  high when state ≠ IDLE.

Behaviour:
- Reset values:
  - state=IDLE, gnt_o=0, last-grant pointer=REQ_NUM-1 (requester 0 wins first), busy_o=0.
  - All tready/tvalid outputs 0.
  - spi_cpol_o=0, spi_cpha_o=0, spi_addr_o=0, spi_div_o=2, spi_wait_o=1.
- IDLE:
  - When |req_tvalid_i, select the first k with tvalid set, searching from last+1 and wrapping modulo REQ_NUM.
  - Register gnt_o=k and latch k's address, CPOL, CPHA, divider and wait into the spi_*_o registers. Go to CFG.
  - No TX ready is given in IDLE.
- CFG (1 cycle): config outputs are stable; the master samples them while idle. Go to XFER.
- XFER:
  - Combinational pass-through: spi_tvalid_o=req_tvalid_i[gnt]; spi_tdata_o/spi_tlast_o come from gnt; req_tready_o[gnt]=spi_tready_i; all other req_tready_o=0.
  - A TX handshake with tlast → DRAIN.
  - A TX handshake with tlast in the same cycle as an RX tlast handshake → IDLE directly.
- DRAIN: spi_tvalid_o=0; wait for the RX tlast handshake → IDLE and last pointer=gnt.
- RX path, in XFER and DRAIN:
  - rsp_tvalid_o[gnt]=spi_rx_tvalid_i, others 0.
  - spi_rx_tready_o=rsp_tready_i[gnt].
  - rsp_tdata_o/rsp_tlast_o pass through.
- RX path, in IDLE/CFG: spi_rx_tready_o=1 (drop stray beats); rsp_tvalid_o=0.
- Latency and config rules:
  - First TX beat can reach the master 2 cycles after the request is seen in IDLE.
  - Config inputs are sampled only at grant; changes mid-packet are ignored.
- Fairness: a requester holding tvalid is served within REQ_NUM-1 other packets.
- Reset mid-packet returns to IDLE next cycle. The master is reset by the same rst_i (inverted for its rstn_i) at top level.

Decomposition:
- Package axis_spi_arbiter_pkg holds:
  - state_e {IDLE, CFG, XFER, DRAIN}, 2-bit.
  - Default config constants (DIV_RST=2, WAIT_RST=1).
- Natural sub-module: rr_arbiter (request vector, enable, last pointer → one-hot/index grant), reusable elsewhere.

Test Plan:
- Single requester: req0 sends 0xA5, 0x3C(tlast) with cpol=1, cpha=1, div=4 → spi_* carry those beats in order; rsp_tvalid_o[0] gets 2 beats, tlast on the second; cpol/cpha/div held throughout.
- Contention: req0 and req1 both valid with 2-beat packets from reset → grant order 0,1,0,1; no interleaving; gnt_o stable for each packet until its RX tlast.
- Config isolation: req0 addr=0/div=4, req1 addr=1/div=8 → spi_addr_o/spi_div_o switch only in CFG; a req0 cpol toggle mid-packet does not change spi_cpol_o.
- Backpressure: rsp_tready_i[gnt]=0 for 10 cycles on the last RX beat → arbiter stays in DRAIN, spi_rx_tready_o=0, no new grant until the handshake.
- Stray RX in IDLE: spi_rx_tvalid_i pulsed with no grant → spi_rx_tready_o=1, all rsp_tvalid_o=0.
- Reset mid-XFER: assert rst_i after 1 beat → next cycle IDLE, all ready/valid 0, gnt_o=0, and the following arbitration starts at requester 0.
